// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - fetch-to-decode instruction queue with JAL predecode and redirect drop window
module fetch_decode_queue #(
    parameter int DEPTH       = 4,
    parameter int DROP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [63:0] fetch_instr_pc,
    output logic        busy,
    output logic        jal,
    output logic [31:0] jal_addr,
    input  logic        jalr_jcond,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int DCW = $clog2(DROP_CYCLES + 1);

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_DROP   = 1'b1;

    logic [63:0]    mem_q [DEPTH];
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [0:0]     state_q, state_d;
    logic [DCW-1:0] drop_cnt_q, drop_cnt_d;
    logic           jal_q, jal_d;
    logic [31:0]    jal_addr_q, jal_addr_d;

    logic        full;
    logic        busy_int;
    logic        not_empty;
    logic        accept;
    logic        pop;
    logic        is_jal;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] jal_imm;
    logic [63:0] head;

    assign in_instr  = fetch_instr_pc[63:32];
    assign in_pc     = fetch_instr_pc[31:0];
    assign full      = (count_q == CW'(DEPTH));
    assign not_empty = (count_q != '0);
    // busy looks only at the registered count, so a same-cycle pop never frees a slot
    assign busy_int  = full || (state_q == ST_DROP);
    assign accept    = fetch_valid && !busy_int && !jalr_jcond && !rst;
    assign pop       = not_empty && dec_ready && !jalr_jcond && !rst;
    assign is_jal    = (in_instr[6:0] == 7'b1101111);
    assign jal_imm   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
    assign head      = mem_q[rptr_q];

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        state_d    = state_q;
        drop_cnt_d = drop_cnt_q;
        jal_d      = 1'b0;
        jal_addr_d = jal_addr_q;
        if (jalr_jcond) begin
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            state_d    = ST_NORMAL;
            drop_cnt_d = '0;
        end else begin
            if (accept) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (state_q == ST_DROP) begin
                if (drop_cnt_q <= DCW'(1)) begin
                    state_d    = ST_NORMAL;
                    drop_cnt_d = '0;
                end else begin
                    drop_cnt_d = drop_cnt_q - 1'b1;
                end
            end
            // A JAL is still enqueued; fetch is told to redirect and the stale beats behind it are dropped
            if (accept && is_jal) begin
                state_d    = ST_DROP;
                drop_cnt_d = DCW'(DROP_CYCLES);
                jal_d      = 1'b1;
                jal_addr_d = in_pc + jal_imm;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            state_q    <= ST_NORMAL;
            drop_cnt_q <= '0;
            jal_q      <= 1'b0;
            jal_addr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            drop_cnt_q <= drop_cnt_d;
            jal_q      <= jal_d;
            jal_addr_q <= jal_addr_d;
            if (accept) begin
                mem_q[wptr_q] <= fetch_instr_pc;
            end
        end
    end

    // Outputs are forced quiet while reset is held, not only after the reset edge
    assign busy      = !rst && busy_int;
    assign dec_valid = !rst && not_empty;
    assign dec_instr = rst ? 32'h0 : head[63:32];
    assign dec_pc    = rst ? 32'h0 : head[31:0];
    assign jal       = jal_q;
    assign jal_addr  = jal_addr_q;
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb/tb_fetch_decode_queue.sv - scoreboard bench for fetch_decode_queue
module tb_fetch_decode_queue;
    localparam int DEPTH = 4;
    localparam int DROP  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [63:0] fetch_instr_pc = '0;
    logic        jalr_jcond = 1'b0;
    logic        dec_ready = 1'b0;
    logic        busy, jal, dec_valid;
    logic [31:0] jal_addr, dec_instr, dec_pc;

    int checks = 0;
    int failures = 0;
    bit started = 1'b0;

    logic [63:0] sb[$];
    int m_count = 0;
    int m_drop = 0;
    bit m_jal = 1'b0;

    fetch_decode_queue #(.DEPTH(DEPTH), .DROP_CYCLES(DROP)) dut (
        .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_instr_pc(fetch_instr_pc),
        .busy(busy), .jal(jal), .jal_addr(jal_addr), .jalr_jcond(jalr_jcond),
        .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model and scoreboard, evaluated mid-cycle while inputs are stable
    always @(negedge clk) begin
        if (started) begin
            bit eb, ev, pop, acc;
            logic [63:0] e;
            eb = !rst && (m_count == DEPTH || m_drop != 0);
            ev = !rst && (m_count != 0);
            chk("busy", busy, eb);
            chk("dec_valid", dec_valid, ev);
            chk("jal", jal, m_jal);
            pop = ev && dec_ready && !jalr_jcond;
            if (ev) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow actual=empty required=entry");
                end else begin
                    e = sb[0];
                    chk("dec_instr", dec_instr, e[63:32]);
                    chk("dec_pc", dec_pc, e[31:0]);
                    if (pop) void'(sb.pop_front());
                end
            end
            acc = fetch_valid && !eb && !jalr_jcond && !rst;
            if (rst || jalr_jcond) begin
                sb.delete();
                m_count = 0;
                m_drop = 0;
                m_jal = 1'b0;
            end else begin
                if (acc) sb.push_back(fetch_instr_pc);
                m_count = m_count + int'(acc) - int'(pop);
                m_jal = acc && (fetch_instr_pc[38:32] == 7'h6F);
                if (m_jal) m_drop = DROP;
                else if (m_drop > 0) m_drop--;
            end
        end
    end

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        bit done;
        done = 1'b0;
        fetch_instr_pc = {instr, pc};
        fetch_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!busy) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_accepted required=accepted pc=%h", pc);
        end
        fetch_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        fetch_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        time t0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        started = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_dec_instr", dec_instr, 0);
        chk("rst_dec_pc", dec_pc, 0);
        chk("rst_jal", jal, 0);
        chk("rst_jal_addr", jal_addr, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill to full with decode stalled, then drain in order
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h00000013, 32'(i * 4));
        @(negedge clk);
        chk("fill_busy", busy, 1);
        fetch_instr_pc = {32'h00000013, 32'd16};
        fetch_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("held_busy", busy, 1);
        chk("held_dec_pc", dec_pc, 0);
        dec_ready = 1'b1;
        send(32'h00000013, 32'd16);
        idle(8);
        @(negedge clk);
        chk("drained_valid", dec_valid, 0);

        // Forward JAL; the two beats behind it are dropped
        send(32'h0100006F, 32'h20);
        fetch_instr_pc = {32'h00000013, 32'h24};
        fetch_valid = 1'b1;
        @(negedge clk);
        chk("jal_pulse", jal, 1);
        chk("jal_target", jal_addr, 32'h30);
        repeat (2) @(posedge clk);
        #1;
        idle(3);
        chk("jal_addr_hold", jal_addr, 32'h30);

        // Backward JAL
        send(32'hFF9FF06F, 32'h100);
        @(negedge clk);
        chk("jal_neg_target", jal_addr, 32'hF8);
        idle(4);

        // Flush while three entries plus a JAL are queued
        dec_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h00000013, 32'h200 + 32'(i * 4));
        send(32'h0100006F, 32'h20C);
        jalr_jcond = 1'b1;
        fetch_instr_pc = {32'h00000013, 32'h500};
        fetch_valid = 1'b1;
        @(posedge clk);
        #1;
        jalr_jcond = 1'b0;
        fetch_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", dec_valid, 0);
        chk("flush_busy", busy, 0);
        chk("flush_jal", jal, 0);
        dec_ready = 1'b1;
        idle(2);

        // Streaming: one accept per cycle with simultaneous pops, pointers wrap
        t0 = $time;
        for (int i = 0; i < 10; i++) send(32'h00000013 | (32'(i) << 20), 32'h1000 + 32'(i * 4));
        chk("wrap_cycles", 64'(($time - t0) / 10), 10);
        idle(3);

        // Reset during the JAL pulse / drop window
        send(32'h0100006F, 32'h60);
        rst = 1'b1;
        fetch_instr_pc = {32'h00000013, 32'h64};
        fetch_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        fetch_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_jal", jal, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", dec_valid, 0);
        chk("mid_rst_instr", dec_instr, 0);
        chk("mid_rst_pc", dec_pc, 0);
        chk("mid_rst_jal_addr", jal_addr, 0);
        send(32'h00000013, 32'h80);
        idle(4);
        chk("sb_empty", 64'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fetch_decode_queue.md
FETCH_DECODE_QUEUE -- requirements
Module: fetch_decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of queue entries (power of 2, at least 2).
REQ-002 SHALL have parameter DROP_CYCLES, default 2, the number of cycles fetch beats are discarded after a JAL redirect (at least 1).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 fetch_valid  in  1  fetch_instr_pc carries a valid beat this cycle.
REQ-006 fetch_instr_pc  in  64  fetched beat; [63:32] = instr, [31:0] = pc.
REQ-007 busy  out  1  queue cannot accept a beat this cycle; fetch holds its beat.
REQ-008 jal  out  1  one-cycle redirect pulse to fetch.
REQ-009 jal_addr  out  32  JAL target; valid while jal=1, held otherwise.
REQ-010 jalr_jcond  in  1  backend flush (JALR or taken branch); fetch redirects itself.
REQ-011 dec_valid  out  1  head entry is valid for decode.
REQ-012 dec_instr  out  32  instr of head entry.
REQ-013 dec_pc  out  32  pc of head entry.
REQ-014 dec_ready  in  1  decode consumes the head entry this cycle.

Function
REQ-015 SHALL implement a DEPTH-entry circular FIFO: write pointer, read pointer, and a count of width log2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-016 busy SHALL be combinational: busy = (count == DEPTH) OR (state == DROP).
REQ-017 Accept SHALL occur when fetch_valid=1, busy=0, jalr_jcond=0, and rst=0; the beat is written at the write pointer.
REQ-018 dec_valid SHALL be (count != 0); dec_instr and dec_pc SHALL reflect the head entry.
REQ-019 Pop SHALL occur when dec_valid=1 and dec_ready=1.
REQ-020 Simultaneous accept and pop SHALL leave count unchanged.
REQ-021 There is no empty bypass: an accepted beat appears on dec_valid exactly 1 cycle after acceptance.
REQ-022 When full, a pop in the same cycle SHALL NOT allow an accept; busy is derived from the current count only.
REQ-023 Predecode: an accepted beat with instr[6:0] == 7'b1101111 is a JAL.
REQ-024 The JAL beat SHALL still be enqueued.
REQ-025 For a JAL, jal_addr SHALL register pc + sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}), computed modulo 2^32.
REQ-026 FSM states SHALL be NORMAL and DROP.
REQ-027 NORMAL -> DROP SHALL occur on an accepted JAL.
REQ-028 In DROP:
- jal=1 only in the first DROP cycle;
- all fetch_valid beats are discarded;
- the state is held for DROP_CYCLES cycles by a down-counter, then returns to NORMAL.
REQ-029 Pops SHALL continue normally during DROP.
REQ-030 jalr_jcond=1 SHALL, on that edge:
- set count=0 and both pointers=0;
- force the state to NORMAL and clear the drop counter;
- discard the beat presented that cycle;
- suppress any jal pulse scheduled for the next cycle.
REQ-031 Pop and accept SHALL be ignored in a jalr_jcond cycle.
REQ-032 Priority SHALL be: rst > jalr_jcond > JAL detect / accept / pop.
REQ-033 jal SHALL never be asserted in two consecutive cycles.
REQ-034 A JAL arriving while full SHALL NOT be accepted; it is detected when it is later accepted.

Reset
REQ-035 With rst=1 at an edge, SHALL set:
- count=0 and pointers=0;
- state=NORMAL and drop counter=0;
- jal=0, jal_addr=0;
- all entries to 0.
REQ-036 During and after reset, outputs SHALL be busy=0, dec_valid=0, dec_instr=0, dec_pc=0.
REQ-037 Reset asserted mid-DROP or mid-jal-pulse SHALL cancel it; jal=0 on the cycle after the reset edge.
REQ-038 fetch_valid beats presented during reset SHALL be discarded.

Verification
REQ-039 Fill/drain:
- stimulus: 5 beats (non-JAL, pc 0,4,8,12,16), dec_ready=0;
- response: busy=1 after the 4th accept, 5th beat held;
- then set dec_ready=1: pcs pop in order 0,4,8,12,16, dec_valid=0 afterwards.
REQ-040 JAL target:
- stimulus: beat instr=32'h0100006F (jal x0,+16), pc=32'h00000020;
- response: next cycle jal=1, jal_addr=32'h00000030;
- the following 2 beats are dropped; the JAL entry is popped normally.
REQ-041 Negative JAL:
- stimulus: instr=32'hFF9FF06F (jal x0,-8), pc=32'h00000100;
- response: jal_addr=32'h000000F8.
REQ-042 Flush:
- stimulus: queue holding 3 entries plus a JAL accepted; jalr_jcond=1 on the next cycle;
- response: count=0, dec_valid=0, jal stays 0, busy=0 the following cycle.
REQ-043 Wrap and concurrency:
- stimulus: 10 beats with dec_ready=1 continuously;
- response: after the first beat's initial 1-cycle latency, one accept and one pop every cycle, count steady at 1, pointers wrap, data in order.
REQ-044 Reset mid-DROP:
- stimulus: rst=1 the cycle after a JAL accept;
- response: jal=0, all outputs at reset values, the next beat is accepted normally.
